// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier slice.
//   mult_state_e : sequencer state encoding (IDLE, RUN, SIGN, DONE)
//   MULT_WIDTH   : default operand width
//   MULT_CNT_W   : default iteration-counter width (2**MULT_CNT_W > MULT_WIDTH)
//   cond_abs()   : two's-complement magnitude, applied only for signed operands
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN,
        DONE
    } mult_state_e;

    // |v| when is_signed, raw v otherwise; |MIN_INT| wraps to itself and is
    // then read as an unsigned magnitude.
    function automatic logic [MULT_WIDTH-1:0] cond_abs(
        input logic [MULT_WIDTH-1:0] v,
        input logic                  is_signed
    );
        return (is_signed && v[MULT_WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath for the sequential multiplier.
// Holds multiplicand (2*WIDTH), multiplier, accumulator, sign flag and the
// HI/LO result registers.
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           synchronous reset, active-low
//   load_i           capture operands (magnitudes) and clear accumulator
//   step_i           one shift-add iteration
//   finish_i         write signed-corrected product into HI/LO
//   sign_i           signed operation, sampled with load_i
//   srca_i, srcb_i   multiplicand / multiplier, sampled with load_i
//   hi_o, lo_o       upper / lower product word
//   mplier_last_o    remaining multiplier bits after this step are all zero
//                    (port exists only when MULT_EARLY_TERM_EN is defined)
module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             finish_i,
    input  logic             sign_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
`ifdef MULT_EARLY_TERM_EN
    output logic             mplier_last_o,
`endif
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] result;

    // The package helper is fixed at MULT_WIDTH; other widths use the same
    // expression inline.
    if (WIDTH == MULT_WIDTH) begin : g_pkg_abs
        assign abs_a = cond_abs(srca_i, sign_i);
        assign abs_b = cond_abs(srcb_i, sign_i);
    end else begin : g_inline_abs
        assign abs_a = (sign_i && srca_i[WIDTH-1]) ? (~srca_i + 1'b1) : srca_i;
        assign abs_b = (sign_i && srcb_i[WIDTH-1]) ? (~srcb_i + 1'b1) : srcb_i;
    end

    assign result = neg_q ? (~acc_q + 1'b1) : acc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (load_i) begin
                mcand_q  <= {{WIDTH{1'b0}}, abs_a};
                mplier_q <= abs_b;
                acc_q    <= '0;
                neg_q    <= sign_i & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
            end else if (step_i) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
            if (finish_i) begin
                {hi_q, lo_q} <= result;
            end
        end
    end

`ifdef MULT_EARLY_TERM_EN
    assign mplier_last_o = (mplier_q[WIDTH-1:1] == '0);
`endif

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle sequencer for the pipeline's WIDTH x WIDTH multiplier.
// Runs the shift-add datapath, owns the iteration counter, busy/done flags
// and the stall request to the hazard unit.
// Ports:
//   clk         clock, rising edge
//   reset       synchronous reset, active-low
//   start_mult  start request from decode
//   mult_sign   1 = signed multiply, sampled with start_mult
//   srca, srcb  operands, sampled with start_mult
//   mf_read     decode-stage instruction reads HI/LO
//   hi, lo      product words (change only on SIGN->DONE or reset)
//   busy        multiply in RUN or SIGN
//   done        one-cycle pulse, hi/lo freshly updated
//   stall_mult  busy & (mf_read | start_mult), combinational
// Build option: MULT_EARLY_TERM_EN ends RUN as soon as the remaining
// multiplier bits are zero.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = MULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mf_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_mult
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    logic load;
    logic step;
    logic finish;
    logic early_term;

    assign load   = ((state_q == IDLE) || (state_q == DONE)) && start_mult;
    assign step   = (state_q == RUN);
    assign finish = (state_q == SIGN);

    mult_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i         (clk),
        .rst_ni        (reset),
        .load_i        (load),
        .step_i        (step),
        .finish_i      (finish),
        .sign_i        (mult_sign),
        .srca_i        (srca),
        .srcb_i        (srcb),
`ifdef MULT_EARLY_TERM_EN
        .mplier_last_o (early_term),
`endif
        .hi_o          (hi),
        .lo_o          (lo)
    );

`ifndef MULT_EARLY_TERM_EN
    assign early_term = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_mult) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if ((cnt_q == LAST_CNT) || early_term) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign stall_mult = busy_q & (mf_read | start_mult);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        mult_sign = 1'b0;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic        mf_read = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall_mult;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected contents of HI/LO as tracked by the bench.
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    mult_seq_ctrl #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .mult_sign  (mult_sign),
        .srca       (srca),
        .srcb       (srcb),
        .mf_read    (mf_read),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .stall_mult (stall_mult)
    );

    always #5 clk = ~clk;

    // Cycle in which done is expected, counting the start cycle as 0.
    function automatic int exp_lat(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int h;
        int lat;
        m = (s && b[31]) ? (~b + 32'd1) : b;
        h = 0;
        for (int i = 0; i < 32; i++) if (m[i]) h = i;
        lat = h + 3;
`ifndef MULT_EARLY_TERM_EN
        lat = 34;
`endif
        return lat;
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        start_mult = 1'b0;
        mf_read = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (stall_mult !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_mult); end
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got=%h_%h exp=0", hi, lo); end
        @(negedge clk);
        reset = 1'b1;
        mf_read = 1'b0;
        cur_hi = '0;
        cur_lo = '0;
    endtask

    // One multiply from IDLE/DONE with full per-cycle checking.
    task automatic do_mult(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic mf0,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        lat = exp_lat(b, s);
        @(negedge clk);
        srca = a; srcb = b; mult_sign = s; start_mult = 1'b1; mf_read = mf0;
        #1;
        n_cmp++; if (stall_mult !== 1'b0) begin n_fail++; $display("FAIL %s c0_stall got=%b exp=0", nm, stall_mult); end
        n_cmp++; if ({hi, lo} !== {cur_hi, cur_lo}) begin n_fail++; $display("FAIL %s c0_hilo got=%h_%h exp=%h_%h", nm, hi, lo, cur_hi, cur_lo); end
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            start_mult = 1'b0;
            mf_read = 1'b0;
            #1;
            n_cmp++; if (busy !== (k < lat)) begin n_fail++; $display("FAIL %s busy c%0d got=%b exp=%b", nm, k, busy, (k < lat)); end
            n_cmp++; if (done !== (k == lat)) begin n_fail++; $display("FAIL %s done c%0d got=%b exp=%b", nm, k, done, (k == lat)); end
            if (k < lat) begin
                n_cmp++; if ({hi, lo} !== {cur_hi, cur_lo}) begin n_fail++; $display("FAIL %s hold c%0d got=%h_%h exp=%h_%h", nm, k, hi, lo, cur_hi, cur_lo); end
            end else begin
                n_cmp++; if ({hi, lo} !== {ehi, elo}) begin n_fail++; $display("FAIL %s result c%0d got=%h_%h exp=%h_%h", nm, k, hi, lo, ehi, elo); end
            end
        end
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    task automatic test_unsigned;
        do_mult("u_3x5",     32'd3,        32'd5,        1'b0, 1'b0, 32'h00000000, 32'h0000000F);
        do_mult("u_ffxff",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        do_mult("u_m3x5",    32'hFFFFFFFD, 32'd5,        1'b0, 1'b0, 32'h00000004, 32'hFFFFFFF1);
    endtask

    task automatic test_signed;
        do_mult("s_m3x5",    32'hFFFFFFFD, 32'd5,        1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        do_mult("s_minxmin", 32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h40000000, 32'h00000000);
        do_mult("s_minx1",   32'h80000000, 32'd1,        1'b1, 1'b0, 32'hFFFFFFFF, 32'h80000000);
        do_mult("s_m3xm7",   32'hFFFFFFFD, 32'hFFFFFFF9, 1'b1, 1'b0, 32'h00000000, 32'h00000015);
    endtask

    // start_mult and mf_read together in IDLE: no stall, old hi/lo visible.
    task automatic test_idle_read;
        do_mult("idle_rd",   32'd11,       32'd13,       1'b0, 1'b1, 32'h00000000, 32'd143);
    endtask

    task automatic test_early_term;
        do_mult("et_7x2",    32'd7,        32'd2,        1'b0, 1'b0, 32'h00000000, 32'd14);
        do_mult("et_9x0",    32'd9,        32'd0,        1'b0, 1'b0, 32'h00000000, 32'd0);
    endtask

    // mf_read in cycles 5..40, second start requested from cycle 10 and held
    // until accepted in the DONE cycle.
    task automatic test_stall;
        int l1, l2;
        logic eb, es, ed, st;
        logic [63:0] eres;
        l1 = exp_lat(32'h80000001, 1'b0);
        l2 = exp_lat(32'h00000020, 1'b0);
        @(negedge clk);
        srca = 32'd3; srcb = 32'h80000001; mult_sign = 1'b0; start_mult = 1'b1; mf_read = 1'b0;
        #1;
        for (int k = 1; k <= l1 + l2 + 2; k++) begin
            @(negedge clk);
            st = (k >= 10) && (k <= l1);
            start_mult = st;
            if (k == 10) begin
                srca = 32'h10;
                srcb = 32'h20;
            end
            mf_read = (k >= 5) && (k <= 40);
            #1;
            eb = ((k >= 1) && (k <= l1 - 1)) || ((k >= l1 + 1) && (k <= l1 + l2 - 1));
            es = eb && (mf_read || st);
            ed = (k == l1) || (k == l1 + l2);
            if (k < l1) eres = {cur_hi, cur_lo};
            else if (k < l1 + l2) eres = 64'h00000001_80000003;
            else eres = 64'h00000000_00000200;
            n_cmp++; if (stall_mult !== es) begin n_fail++; $display("FAIL stall c%0d got=%b exp=%b", k, stall_mult, es); end
            n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL stall_busy c%0d got=%b exp=%b", k, busy, eb); end
            n_cmp++; if (done !== ed) begin n_fail++; $display("FAIL stall_done c%0d got=%b exp=%b", k, done, ed); end
            n_cmp++; if ({hi, lo} !== eres) begin n_fail++; $display("FAIL stall_hilo c%0d got=%h_%h exp=%h", k, hi, lo, eres); end
        end
        mf_read = 1'b0;
        start_mult = 1'b0;
        cur_hi = 32'h0;
        cur_lo = 32'h200;
    endtask

    // Reset low for one edge at cycle 15 of a running multiply.
    task automatic test_mid_reset;
        @(negedge clk);
        srca = 32'd6; srcb = 32'h40000000; mult_sign = 1'b0; start_mult = 1'b1;
        #1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_mult = 1'b0;
            reset = (k == 15) ? 1'b0 : 1'b1;
            #1;
            if (k == 14) begin
                n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mrst_prebusy got=%b exp=1", busy); end
            end
            if (k == 16) begin
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got=%b exp=0", busy); end
                n_cmp++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL mrst_hilo got=%h_%h exp=0", hi, lo); end
            end
            if (k >= 16) begin
                n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mrst_done c%0d got=%b exp=0", k, done); end
            end
        end
        reset = 1'b1;
        cur_hi = '0;
        cur_lo = '0;
        do_mult("mrst_after", 32'd6, 32'h40000000, 1'b0, 1'b0, 32'h00000001, 32'h80000000);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_idle_read();
        test_early_term();
        test_stall();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer for the pipeline's 32x32 multiplier, launched by decode-stage `start_mult`/`mult_sign`.
- Owns the iterative shift-add engine and the HI/LO result registers.
- Generates the stall request that freezes the pipeline when an instruction needs HI/LO or a new multiply while one is in flight.
- Sits beside the EX stage and feeds the hazard logic and the `outselect_d` HI/LO mux.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-low (asserted when 0).
- start_mult  input  1  start request from decode-stage control.
- mult_sign  input  1  1 = signed multiply, 0 = unsigned; sampled with start_mult.
- srca  input  WIDTH  multiplicand, sampled with start_mult.
- srcb  input  WIDTH  multiplier, sampled with start_mult.
- mf_read  input  1  decode-stage instruction reads HI or LO (mfhi/mflo).
- hi  output  WIDTH  upper product word.
- lo  output  WIDTH  lower product word.
- busy  output  1  a multiply is in progress.
- done  output  1  one-cycle pulse; hi/lo updated.
- stall_mult  output  1  stall request to the hazard unit.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; hi=0, lo=0, busy=0, done=0, stall_mult=0; counter and working registers cleared. Reset mid-operation aborts the multiply and discards any partial result.
- States: IDLE, RUN, SIGN, DONE.
- IDLE or DONE with start_mult==1:
  - load mcand = |srca| (zero-extended to 2*WIDTH) and mplier = |srcb|.
  - Absolute value is taken only if mult_sign==1; otherwise operands are used raw.
  - neg = mult_sign & (srca[MSB] ^ srcb[MSB]); acc=0; cnt=0; next state RUN.
- DONE with start_mult==0: next state IDLE. DONE lasts exactly one cycle.
- RUN, each cycle:
  - if mplier[0], acc += mcand (2*WIDTH-bit add, carry discarded);
  - mcand <<= 1; mplier >>= 1; cnt++;
  - after the WIDTH-th iteration (cnt == WIDTH-1 at the edge), go to SIGN.
- SIGN: {hi,lo} = neg ? (~acc + 1) : acc; next state DONE.
- |0x80000000| is 0x80000000 interpreted unsigned; no overflow special case.
- Latency (start sampled in cycle 0):
  - RUN occupies cycles 1..WIDTH; SIGN is cycle WIDTH+1; DONE is cycle WIDTH+2.
  - done=1 and new hi/lo are visible in cycle WIDTH+2 (cycle 34 at default).
- hi/lo change only on the SIGN->DONE edge (or reset); otherwise they hold the last result.
- busy = (state==RUN || state==SIGN).
- stall_mult = busy & (mf_read | start_mult). This is combinational from the inputs and state.
- start_mult while busy is ignored; the stall holds it in decode until it is accepted in DONE or IDLE.
- mf_read in the DONE cycle does not stall and sees the new hi/lo.
- Simultaneous start_mult and mf_read in IDLE: no stall; mf_read sees the old hi/lo.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in RUN, if the post-shift mplier==0, transition to SIGN immediately (skipping the remaining iterations). Also, an operand pair with |srcb|==0 at start goes RUN->SIGN after 1 cycle.
  - Resulting latency: (index of highest set bit of |srcb|) + 3 cycles, minimum 3.
  - done still pulses for exactly one cycle and the result is identical.
- Undefined: fixed WIDTH+2-cycle latency regardless of operand values.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE, RUN, SIGN, DONE);
  - MULT_WIDTH=32 constant;
  - MULT_CNT_W constant;
  - function for the conditional two's-complement absolute value.
- One natural sub-module: mult_shift_add_dp (mcand/mplier/acc registers and adder), driven by load/step/finish strobes from this FSM. The FSM, counter, stall and done logic stay in mult_seq_ctrl.

Test Plan:
- Unsigned 3*5, start in cycle 0 -> busy cycles 1-33, done=1 in cycle 34 only, hi=0x00000000, lo=0x0000000F.
- Signed 0xFFFFFFFD*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0; signed 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
- mf_read=1 in cycles 5-40 after a start in cycle 0 -> stall_mult=1 for cycles 5-33, 0 in cycle 34; second start_mult at cycle 10 -> stall_mult=1 and hi/lo unchanged until the first done.
- reset=0 for one edge at cycle 15 of a running multiply -> next cycle busy=0, hi=lo=0, no done pulse; a new start afterwards completes normally.
- With MULT_EARLY_TERM_EN, 7*2 -> done in cycle 4, lo=14; 9*0 -> done in cycle 3, lo=0. Without the macro, both give done in cycle 34.
